// File: rtl/udar_pkg.sv
// Shared types and default 50 MHz timing for the ultrasonic ranger emulator and its controller.
package udar_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG_HI,
    BURST,
    ECHO,
    HOLDOFF
  } udar_state_e;

  // mm <-> cycle scaling must match the controller's capture logic
  localparam int TRIG_MIN_CYC_DEF  = 500;
  localparam int BURST_DLY_CYC_DEF = 25000;
  localparam int CYC_PER_MM_DEF    = 290;
  localparam int DIST_W_DEF        = 12;
  localparam int TIMEOUT_CYC_DEF   = 1900000;
  localparam int HOLDOFF_CYC_DEF   = 50000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/udar_sync_edge.sv
// Two-flop synchronizer for an asynchronous input plus rise/fall detect on the synced value.
module udar_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign q    = s2;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

endmodule

// File: rtl/udar_echo_emu.sv
// HC-SR04-style responder: qualifies a trig pulse, waits the burst delay, then
// drives an echo pulse whose width encodes the latched distance.
module udar_echo_emu
  import udar_pkg::*;
#(
  parameter int TRIG_MIN_CYC  = TRIG_MIN_CYC_DEF,
  parameter int BURST_DLY_CYC = BURST_DLY_CYC_DEF,
  parameter int CYC_PER_MM    = CYC_PER_MM_DEF,
  parameter int DIST_W        = DIST_W_DEF,
  parameter int TIMEOUT_CYC   = TIMEOUT_CYC_DEF,
  parameter int HOLDOFF_CYC   = HOLDOFF_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              en,
  input  logic              trig,
  input  logic [DIST_W-1:0] dist_mm,
  input  logic              target_ok,
  output logic              echo,
  output logic              busy,
  output logic              done,
  output logic              trig_err,
  output udar_state_e       dbg_state
);

  localparam int WW    = $clog2(TIMEOUT_CYC + 1) + 1;
  localparam int CNT_W = max3(WW, $clog2(BURST_DLY_CYC + 1), $clog2(HOLDOFF_CYC + 1));
  localparam int HC_W  = $clog2(TRIG_MIN_CYC + 1);

  logic trig_s, trig_rise, trig_fall;

  udar_sync_edge u_sync (
    .clk  (clk),
    .rst  (rst_i),
    .d    (trig),
    .q    (trig_s),
    .rise (trig_rise),
    .fall (trig_fall)
  );

  udar_state_e       state_q, state_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [HC_W-1:0]   hcnt_q, hcnt_n;
  logic              armed_q, armed_n;
  logic              echo_q, echo_n;
  logic              done_q, done_n;
  logic              err_q, err_n;
  logic              busy_q, busy_n;
  logic [DIST_W-1:0] dist_q, dist_n;
  logic              tgt_q, tgt_n;
  logic [WW-1:0]     width_q, width_n;

  // Echo width from the latched request; 0 mm reads as 1 mm, long or missing targets clamp to timeout
  logic [DIST_W-1:0] dist_eff;
  logic [63:0]       prod;
  logic [WW-1:0]     width_calc;
  logic [CNT_W-1:0]  echo_last;

  always_comb begin
    dist_eff   = (dist_q == '0) ? DIST_W'(1) : dist_q;
    prod       = 64'(dist_eff) * 64'(CYC_PER_MM);
    if (!tgt_q || prod > 64'(TIMEOUT_CYC)) width_calc = WW'(TIMEOUT_CYC);
    else                                   width_calc = prod[WW-1:0];
    echo_last  = CNT_W'(width_q) - CNT_W'(1);
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    hcnt_n  = hcnt_q;
    armed_n = armed_q;
    echo_n  = 1'b0;
    done_n  = 1'b0;
    err_n   = 1'b0;
    dist_n  = dist_q;
    tgt_n   = tgt_q;
    width_n = width_q;

    // Arming needs trig seen low in IDLE, so a trig held across HOLDOFF cannot retrigger
    if (state_q == IDLE && !trig_s) armed_n = 1'b1;

    if (!en) begin
      state_n = IDLE;
      cnt_n   = '0;
      hcnt_n  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (trig_rise && armed_q) begin
            state_n = TRIG_HI;
            hcnt_n  = '0;
            armed_n = 1'b0;
          end
        end
        TRIG_HI: begin
          if (trig_fall) begin
            hcnt_n = '0;
            if (hcnt_q >= HC_W'(TRIG_MIN_CYC)) begin
              state_n = BURST;
              cnt_n   = '0;
              dist_n  = dist_mm;
              tgt_n   = target_ok;
            end else begin
              state_n = IDLE;
              err_n   = 1'b1;
            end
          end else if (trig_s && hcnt_q != HC_W'(TRIG_MIN_CYC)) begin
            hcnt_n = hcnt_q + HC_W'(1);
          end
        end
        BURST: begin
          width_n = width_calc;
          if (cnt_q == CNT_W'(BURST_DLY_CYC - 1)) begin
            state_n = ECHO;
            cnt_n   = '0;
            echo_n  = 1'b1;
          end else begin
            cnt_n = cnt_q + CNT_W'(1);
          end
        end
        ECHO: begin
          if (cnt_q == echo_last) begin
            state_n = HOLDOFF;
            cnt_n   = '0;
            done_n  = 1'b1;
          end else begin
            echo_n = 1'b1;
            cnt_n  = cnt_q + CNT_W'(1);
          end
        end
        HOLDOFF: begin
          if (cnt_q == CNT_W'(HOLDOFF_CYC - 1)) begin
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_q + CNT_W'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hcnt_q  <= '0;
      armed_q <= 1'b0;
      echo_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      dist_q  <= '0;
      tgt_q   <= 1'b0;
      width_q <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      hcnt_q  <= hcnt_n;
      armed_q <= armed_n;
      echo_q  <= echo_n;
      done_q  <= done_n;
      err_q   <= err_n;
      busy_q  <= busy_n;
      dist_q  <= dist_n;
      tgt_q   <= tgt_n;
      width_q <= width_n;
    end
  end

  assign echo      = echo_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign trig_err  = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_udar_echo_emu.sv
// Directed bench for udar_echo_emu with short timing overrides and hand-computed echo timing.
module tb_udar_echo_emu;
  import udar_pkg::*;

  localparam int TRIG_MIN  = 10;
  localparam int BURST_DLY = 20;
  localparam int CPM       = 4;
  localparam int TIMEOUT   = 1000;
  localparam int HOLDOFF   = 50;
  localparam int SYNC_LAT  = 2;

  logic        clk = 1'b0;
  logic        rst_i, en, trig, target_ok;
  logic [11:0] dist_mm;
  logic        echo, busy, done, trig_err;
  udar_state_e dbg_state;

  udar_echo_emu #(
    .TRIG_MIN_CYC  (TRIG_MIN),
    .BURST_DLY_CYC (BURST_DLY),
    .CYC_PER_MM    (CPM),
    .DIST_W        (12),
    .TIMEOUT_CYC   (TIMEOUT),
    .HOLDOFF_CYC   (HOLDOFF)
  ) dut (
    .clk       (clk),
    .rst_i     (rst_i),
    .en        (en),
    .trig      (trig),
    .dist_mm   (dist_mm),
    .target_ok (target_ok),
    .echo      (echo),
    .busy      (busy),
    .done      (done),
    .trig_err  (trig_err),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // output monitor
  int   n_echo = 0, n_done = 0, n_err = 0;
  int   rise_cyc = 0, fall_cyc = 0, done_cyc = -1, busy_fall_cyc = 0;
  int   run = 0, last_width = 0;
  logic busy_at_err = 1'b0;
  logic prev_echo = 1'b0, prev_busy = 1'b0;

  always @(negedge clk) begin
    if (echo && !prev_echo) begin
      rise_cyc = cyc;
      run = 0;
      n_echo++;
    end
    if (echo) run++;
    if (!echo && prev_echo) begin
      last_width = run;
      fall_cyc = cyc;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (trig_err) begin
      n_err++;
      busy_at_err = busy;
    end
    if (!busy && prev_busy) busy_fall_cyc = cyc;
    prev_echo = echo;
    prev_busy = busy;
  end

  // scoreboard
  int n_vec = 0, n_miss = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic trig_pulse(input int n, output int c0);
    trig = 1'b1;
    tick(n);
    trig = 1'b0;
    c0 = cyc;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while ((busy || echo) && k < budget) begin
      tick(1);
      k++;
    end
    check_val(tag, busy, 0);
  endtask

  task automatic wait_echo(input string tag, input logic lvl, input int budget);
    int k = 0;
    while (echo !== lvl && k < budget) begin
      tick(1);
      k++;
    end
    check_val(tag, echo, lvl);
  endtask

  task automatic measure(input string tag, output int c0);
    trig_pulse(12, c0);
    wait_idle(tag, 3000);
  endtask

  int c0, c1, e0, d0, r0;

  initial begin
    rst_i = 1'b1; en = 1'b1; trig = 1'b0; target_ok = 1'b1; dist_mm = 12'd100;
    tick(3);
    check_val("rst_echo", echo, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_err", trig_err, 0);
    check_val("rst_state", int'(dbg_state), int'(IDLE));
    rst_i = 1'b0;
    tick(3);

    // nominal 100 mm: echo rises 21 clk after trig_s low, 400 wide
    e0 = n_echo; d0 = n_done;
    measure("nom_idle", c0);
    check_val("nom_rise", rise_cyc, c0 + SYNC_LAT + BURST_DLY + 1);
    check_val("nom_width", last_width, 400);
    check_val("nom_ndone", n_done - d0, 1);
    check_val("nom_necho", n_echo - e0, 1);
    check_val("nom_done_at_fall", done_cyc, fall_cyc);
    check_val("nom_holdoff", busy_fall_cyc - fall_cyc, HOLDOFF);

    // short trigger
    e0 = n_echo; r0 = n_err;
    trig_pulse(5, c0);
    tick(6);
    check_val("short_nerr", n_err - r0, 1);
    check_val("short_busy_at_err", busy_at_err, 0);
    check_val("short_necho", n_echo - e0, 0);
    check_val("short_busy", busy, 0);

    // timeout and clamp
    target_ok = 1'b0;
    measure("to_idle", c0);
    check_val("to_width", last_width, TIMEOUT);
    target_ok = 1'b1; dist_mm = 12'd300;
    measure("clamp_idle", c0);
    check_val("clamp_width", last_width, TIMEOUT);
    dist_mm = 12'd0;
    measure("zero_idle", c0);
    check_val("zero_width", last_width, 4);
    check_val("zero_rise", rise_cyc, c0 + SYNC_LAT + BURST_DLY + 1);
    dist_mm = 12'd100;

    // latch and ignore
    e0 = n_echo; r0 = n_err; d0 = n_done;
    trig_pulse(12, c0);
    tick(5);
    dist_mm = 12'd7;
    wait_echo("latch_rise", 1'b1, 100);
    tick(50);
    trig_pulse(12, c1);
    wait_echo("latch_fall", 1'b0, 1000);
    trig_pulse(12, c1);
    wait_idle("latch_idle", 200);
    tick(30);
    check_val("latch_width", last_width, 400);
    check_val("latch_necho", n_echo - e0, 1);
    check_val("latch_nerr", n_err - r0, 0);
    check_val("latch_ndone", n_done - d0, 1);
    check_val("latch_busy", busy, 0);
    dist_mm = 12'd100;

    // re-arm: trig held high from BURST to well past HOLDOFF
    e0 = n_echo; r0 = n_err;
    trig_pulse(12, c0);
    tick(5);
    trig = 1'b1;
    wait_idle("rearm_idle", 3000);
    tick(40);
    check_val("rearm_quiet", busy, 0);
    check_val("rearm_necho", n_echo - e0, 1);
    trig = 1'b0;
    tick(5);
    measure("rearm_idle2", c0);
    check_val("rearm_width", last_width, 400);
    check_val("rearm_rise", rise_cyc, c0 + SYNC_LAT + BURST_DLY + 1);
    check_val("rearm_necho2", n_echo - e0, 2);
    check_val("rearm_nerr", n_err - r0, 0);

    // abort by en
    d0 = n_done;
    trig_pulse(12, c0);
    wait_echo("en_rise", 1'b1, 100);
    tick(50);
    en = 1'b0;
    tick(1);
    check_val("en_echo", echo, 0);
    check_val("en_busy", busy, 0);
    check_val("en_state", int'(dbg_state), int'(IDLE));
    tick(5);
    check_val("en_ndone", n_done - d0, 0);
    en = 1'b1;
    tick(3);
    measure("en_idle", c0);
    check_val("en_width", last_width, 400);
    check_val("en_ndone2", n_done - d0, 1);

    // abort by async reset
    d0 = n_done;
    trig_pulse(12, c0);
    wait_echo("rst_rise", 1'b1, 100);
    tick(50);
    rst_i = 1'b1;
    #1;
    check_val("arst_echo", echo, 0);
    check_val("arst_busy", busy, 0);
    check_val("arst_state", int'(dbg_state), int'(IDLE));
    tick(2);
    rst_i = 1'b0;
    tick(3);
    check_val("arst_ndone", n_done - d0, 0);
    measure("arst_idle", c0);
    check_val("arst_width", last_width, 400);
    check_val("arst_rise", rise_cyc, c0 + SYNC_LAT + BURST_DLY + 1);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/udar_echo_emu.md
Name: udar_echo_emu

Overview:
- Emulates an HC-SR04-style ultrasonic ranger: the responder end of the trig/echo interface that `ctrl` drives (`trig` out, `cap_sig` in).
- Watches a trigger pulse, waits the burst delay, then drives an echo pulse whose width encodes a programmed distance.
- Used for hardware-in-loop bring-up on the Mojo (echo wired back to `udar_len`) and as the sensor model in `ctrl` testbenches.

Parameters:
- TRIG_MIN_CYC, 500, minimum trig high time in clk cycles for a valid trigger (10 us at 50 MHz).
- BURST_DLY_CYC, 25000, cycles from the qualified trig fall to echo rise (500 us).
- CYC_PER_MM, 290, echo-high cycles per mm of distance (5.8 us/mm round trip).
- DIST_W, 12, width of the distance input.
- TIMEOUT_CYC, 1900000, echo width for no target or overflow (38 ms).
- HOLDOFF_CYC, 50000, dead time after echo falls before a new trigger is accepted (1 ms).

Ports:
- clk  in  1  system clock
- rst_i  in  1  asynchronous, active-high reset
- en  in  1  emulator enable; 0 = ignore trig, echo held low
- trig  in  1  trigger from initiator; may be asynchronous
- dist_mm  in  DIST_W  programmed target distance in mm
- target_ok  in  1  1 = target present; 0 = respond with timeout echo
- echo  out  1  echo pulse to initiator
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse on the echo falling edge
- trig_err  out  1  one-cycle pulse when a trig pulse is shorter than TRIG_MIN_CYC

Behaviour:
- Reset: all outputs are 0, FSM is IDLE, all counters are 0, synchronizer flops are 0, `armed` is 0.
- Input synchronization: `trig` passes through a 2-flop synchronizer; all logic uses the synced value `trig_s`.
- Rising/falling edges are detected on `trig_s` against a third flop.
- Re-arm rule: `armed` sets when `trig_s` is sampled low while in IDLE. A trigger is only accepted when `armed` = 1, so a trig held high across HOLDOFF does not retrigger.
- IDLE:
  - on `trig_s` rising edge with `en` = 1 and `armed` = 1 -> TRIG_HI; clear the high counter; clear `armed`.
- TRIG_HI:
  - the high counter increments each cycle `trig_s` = 1, saturating at TRIG_MIN_CYC.
  - On `trig_s` falling edge: if the count is at least TRIG_MIN_CYC -> BURST, latching `dist_mm` and `target_ok`. Otherwise pulse `trig_err` and go to IDLE.
- BURST:
  - counts BURST_DLY_CYC cycles; echo rises on the first cycle of ECHO.
  - `echo` is registered and goes high exactly BURST_DLY_CYC + 1 clk after the cycle in which `trig_s` is seen low.
- ECHO:
  - Width target W:
    - W = dist_lat × CYC_PER_MM.
    - dist_lat = 0 gives W = CYC_PER_MM (1 mm minimum).
    - target_lat = 0 gives W = TIMEOUT_CYC.
    - W > TIMEOUT_CYC is clamped to TIMEOUT_CYC.
  - The product is computed once at latch time into a register of width clog2(TIMEOUT_CYC + 1) + 1; the multiply may be a one-cycle registered step inside BURST.
  - `echo` stays high for exactly W cycles. On the last cycle, `done` pulses for the cycle in which `echo` falls, then -> HOLDOFF.
- HOLDOFF:
  - `echo` = 0; counts HOLDOFF_CYC cycles, then -> IDLE.
  - trig activity here is ignored.
- `dist_mm` / `target_ok` changes after the latch do not affect the current measurement.
- Trig edges during BURST/ECHO/HOLDOFF are ignored; they cause no error and no retrigger.
- `en` deasserted in any state: go to IDLE next cycle, force `echo` = 0, no `done`, clear counters.
- Reset mid-echo: `echo` drops immediately (async); FSM restarts in IDLE unarmed.
- `busy` = (state != IDLE), registered with the state.

Decomposition:
- Package `udar_pkg`:
  - FSM state enum {IDLE, TRIG_HI, BURST, ECHO, HOLDOFF}.
  - Default timing constants (50 MHz), shared with `ctrl`'s capture logic so that mm↔cycle scaling agrees.
- One natural sub-module, `udar_sync_edge`: 2-flop synchronizer plus rise/fall detect. It is reusable for `udar_rx` and `udar_len` in `ctrl`.

Test Plan:
- Shared bench overrides: TRIG_MIN_CYC=10, BURST_DLY_CYC=20, CYC_PER_MM=4, TIMEOUT_CYC=1000, HOLDOFF_CYC=50.
- Nominal: en=1, target_ok=1, dist_mm=100, trig high 12 cycles -> echo rises 21 clk after `trig_s` falls, is high exactly 400 cycles, `done` pulses once, busy clears 50 cycles after echo falls.
- Short trigger: trig high 5 cycles -> one `trig_err` pulse, echo stays 0, busy returns 0 within 1 cycle.
- Timeout/clamp:
  - target_ok=0 -> echo width 1000.
  - target_ok=1, dist_mm=300 (product 1200) -> echo width 1000.
  - dist_mm=0 -> echo width 4.
- Latch and ignore: dist_mm changes 100 -> 7 during BURST, plus extra trig pulses during ECHO and HOLDOFF -> echo width still 400, no `trig_err`, no second echo.
- Re-arm: trig held high from TRIG_HI through the end of HOLDOFF -> no new measurement until trig goes low then high; the next valid pulse gives a normal echo.
- Abort: en=0 or rst_i asserted 50 cycles into ECHO -> echo low (next cycle / immediately), no `done`, FSM IDLE; a following valid trigger produces a correct 400-cycle echo.
